av_sdram_responder: RTL

AV_SDRAM_RESPONDER -- requirements
Module: av_sdram_responder

---
 rtl/av_sdram_pkg.sv | 29 ++
 rtl/av_resp_mem.sv | 56 +++++
 rtl/av_sdram_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/av_sdram_pkg.sv
// ----------------------------------------------------------------------------
// av_sdram_pkg
// Shared definitions for the Avalon SDRAM responder model: controller state
// encoding and the default values of the top-level parameters.
// ----------------------------------------------------------------------------
package av_sdram_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        READY   = 2'd1,
        REFRESH = 2'd2
    } state_e;

    localparam int DATA_WIDTH               = 16;
    localparam int DEF_ADDR_WIDTH           = 22;
    localparam int DEF_MEM_DEPTH_LOG2       = 12;
    localparam int DEF_READ_LATENCY         = 3;
    localparam int DEF_INIT_CYCLES          = 8;
    localparam int DEF_REFRESH_INTERVAL     = 64;
    localparam int DEF_REFRESH_CYCLES       = 4;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/av_resp_mem.sv
// ----------------------------------------------------------------------------
// av_resp_mem
// Byte-enabled 16-bit single-port RAM with a one-cycle registered read.
// The read register holds 0 in any cycle that follows a non-read, so the
// downstream pipeline never has to gate data with its valid bit.
//
// Ports:
//   clk        - clock
//   sync_reset - synchronous active-high reset (read register only)
//   we_i       - write strobe (commits at this clock edge)
//   re_i       - read strobe (data appears on rdata_o next cycle)
//   addr_i     - word index
//   be_n_i     - active-low byte enables for writes
//   wdata_i    - write data
//   rdata_o    - registered read data, 0 when the previous cycle was not a read
// ----------------------------------------------------------------------------
module av_resp_mem
    import av_sdram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [1:0]            be_n_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the storage array has no reset branch; contents must survive
    // sync_reset, and a resettable array would not map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (!be_n_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
            if (!be_n_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/av_sdram_responder.sv
// ----------------------------------------------------------------------------
// av_sdram_responder
// Behavioural Avalon-MM slave standing in for an SDRAM controller: a small
// byte-enabled backing store, fixed read latency, an initial busy period and
// periodic refresh stalls signalled through waitrequest.
//
// Ports:
//   clk, sync_reset          - clock, synchronous active-high reset
//   sdram_av_address         - word address (low MEM_DEPTH_LOG2 bits used)
//   sdram_av_byteenable_n    - active-low byte enables
//   sdram_av_chipselect      - request qualifier
//   sdram_av_read_n/write_n  - active-low read / write commands
//   sdram_av_writedata       - write data
//   sdram_av_readdata        - read data, 0 whenever readdatavalid is 0
//   sdram_av_readdatavalid   - one-cycle pulse per read, READ_LATENCY later
//   sdram_av_waitrequest     - registered busy flag (INIT / REFRESH)
//   protocol_error           - sticky: read and write requested together
// ----------------------------------------------------------------------------
module av_sdram_responder
    import av_sdram_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH_LOG2   = DEF_MEM_DEPTH_LOG2,
    parameter int READ_LATENCY     = DEF_READ_LATENCY,
    parameter int INIT_CYCLES      = DEF_INIT_CYCLES,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int REFRESH_CYCLES   = DEF_REFRESH_CYCLES
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [ADDR_WIDTH-1:0] sdram_av_address,
    input  logic [1:0]            sdram_av_byteenable_n,
    input  logic                  sdram_av_chipselect,
    input  logic                  sdram_av_read_n,
    input  logic                  sdram_av_write_n,
    input  logic [DATA_WIDTH-1:0] sdram_av_writedata,
    output logic [DATA_WIDTH-1:0] sdram_av_readdata,
    output logic                  sdram_av_readdatavalid,
    output logic                  sdram_av_waitrequest,
    output logic                  protocol_error
);

    localparam int CNT_MAX = max3(INIT_CYCLES, REFRESH_INTERVAL, REFRESH_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wait_q;
    logic               err_q, err_d;

    logic               req_ok, wr_acc, rd_acc, both_acc;
    logic [MEM_DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [READ_LATENCY-1:0]   vld_q;

    // A simultaneous read+write is executed as a write only.
    assign req_ok   = sdram_av_chipselect && !wait_q && !sync_reset;
    assign wr_acc   = req_ok && !sdram_av_write_n;
    assign rd_acc   = req_ok && !sdram_av_read_n && sdram_av_write_n;
    assign both_acc = wr_acc && !sdram_av_read_n;

    // Upper address bits alias onto the backing store.
    assign mem_addr = sdram_av_address[MEM_DEPTH_LOG2-1:0];
    if (ADDR_WIDTH > MEM_DEPTH_LOG2) begin : g_alias
        logic unused_upper;
        assign unused_upper = ^sdram_av_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
    end

    // One counter serves all three states; it restarts on every transition.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        err_d   = err_q | both_acc;
        case (state_q)
            INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (cnt_q == CNT_W'(REFRESH_INTERVAL - 1)) begin
                    state_d = REFRESH;
                    cnt_d   = '0;
                end
            end
            REFRESH: begin
                if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // waitrequest is registered from the next state, so it always equals
    // (state_q != READY) without any path from the bus inputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            wait_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= (state_d != READY);
            err_q   <= err_d;
        end
    end

    av_resp_mem #(
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_mem (
        .clk        (clk),
        .sync_reset (sync_reset),
        .we_i       (wr_acc),
        .re_i       (rd_acc),
        .addr_i     (mem_addr),
        .be_n_i     (sdram_av_byteenable_n),
        .wdata_i    (sdram_av_writedata),
        .rdata_o    (mem_rdata)
    );

    // Valid shift register: stage 0 lines up with the RAM's read register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data stages carry 0 for empty slots, so readdata needs no gating.
    if (READ_LATENCY == 1) begin : g_lat1
        assign sdram_av_readdata = mem_rdata;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY-1];
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                for (int i = 0; i < READ_LATENCY - 1; i++) dat_q[i] <= '0;
            end else begin
                dat_q[0] <= mem_rdata;
                for (int i = 1; i < READ_LATENCY - 1; i++) dat_q[i] <= dat_q[i-1];
            end
        end
        assign sdram_av_readdata = dat_q[READ_LATENCY-2];
    end

    assign sdram_av_readdatavalid = vld_q[READ_LATENCY-1];
    assign sdram_av_waitrequest   = wait_q;
    assign protocol_error         = err_q;

endmodule
